// File: rtl/food_manager_pkg.sv
// Shared definitions for the food placement block: main FSM codes, grid defaults,
// LFSR constants and the local FSM encoding.
package food_manager_pkg;

    localparam int DEF_GRID_W    = 32;
    localparam int DEF_GRID_H    = 24;
    localparam int DEF_COORD_W   = 5;
    localparam int DEF_SEG_MAX   = 20;
    localparam int DEF_ACC_EVERY = 4;
    localparam int DEF_WIN_SCORE = 15;

    localparam logic [15:0] DEF_SEED  = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [2:0] MAIN_IDLE  = 3'd0;
    localparam logic [2:0] MAIN_START = 3'd1;
    localparam logic [2:0] MAIN_GAME1 = 3'd2;
    localparam logic [2:0] MAIN_GAME2 = 3'd3;
    localparam logic [2:0] MAIN_GAME3 = 3'd4;
    localparam logic [2:0] MAIN_WIN   = 3'd5;
    localparam logic [2:0] MAIN_LOSE  = 3'd6;

    typedef enum logic [1:0] {
        FM_IDLE   = 2'd0,
        FM_PLACE  = 2'd1,
        FM_CHECK  = 2'd2,
        FM_ACTIVE = 2'd3
    } fm_state_t;

    function automatic logic is_game(input logic [2:0] s);
        return (s == MAIN_GAME1) || (s == MAIN_GAME2) || (s == MAIN_GAME3);
    endfunction

endpackage

// File: rtl/food_manager_lfsr16.sv
// 16-bit Fibonacci LFSR, free running every cycle; kept separate so obstacle
// placement can reuse the same generator.
module lfsr16
    import food_manager_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_SEED
) (
    input  logic        clk,
    input  logic        rst_global_n,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_global_n) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/food_manager.sv
// Food placement and eat detection: draws candidates from the LFSR, validates them
// serially against the body, then tests the head on every step; keeps score and win.
module food_manager
    import food_manager_pkg::*;
#(
    parameter int          GRID_W    = DEF_GRID_W,
    parameter int          GRID_H    = DEF_GRID_H,
    parameter int          COORD_W   = DEF_COORD_W,
    parameter int          SEG_MAX   = DEF_SEG_MAX,
    parameter int          ACC_EVERY = DEF_ACC_EVERY,
    parameter int          WIN_SCORE = DEF_WIN_SCORE,
    parameter logic [15:0] SEED      = DEF_SEED
) (
    input  logic                       clk,
    input  logic                       rst_global_n,
    input  logic [2:0]                 state,
    input  logic                       step,
    input  logic [4:0]                 snake_len,
    input  logic [SEG_MAX*COORD_W-1:0] body_x,
    input  logic [SEG_MAX*COORD_W-1:0] body_y,
    output logic [COORD_W-1:0]         food_x,
    output logic [COORD_W-1:0]         food_y,
    output logic                       food_valid,
    output logic                       ate,
    output logic                       accelerate,
    output logic [7:0]                 score,
    output logic                       win,
    output fm_state_t                  dbg_state,
    output logic [15:0]                dbg_lfsr
);

    localparam logic [COORD_W:0] W_LIM   = (COORD_W+1)'(GRID_W);
    localparam logic [COORD_W:0] H_LIM   = (COORD_W+1)'(GRID_H);
    localparam logic [4:0]       SEG_LIM = 5'(SEG_MAX);

    fm_state_t          fsm, fsm_next;
    logic [15:0]        lfsr_q;
    logic [4:0]         seg_idx;
    logic [4:0]         len_eff, last_idx;
    logic [COORD_W-1:0] cand_x, cand_y;
    logic [COORD_W-1:0] lfsr_x, lfsr_y;
    logic [COORD_W-1:0] seg_x, seg_y, head_x, head_y;
    logic               in_game, load_cand, seg_inc, place_food, hit, acc_hit;
    logic [7:0]         score_new;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk          (clk),
        .rst_global_n (rst_global_n),
        .q            (lfsr_q)
    );

    assign dbg_state = fsm;
    assign dbg_lfsr  = lfsr_q;
    assign in_game   = is_game(state);
    assign lfsr_x    = lfsr_q[COORD_W-1:0];
    assign lfsr_y    = lfsr_q[2*COORD_W-1:COORD_W];

    // Zero length behaves as a head-only snake; longer than the bus is clipped.
    assign len_eff  = (snake_len == 5'd0) ? 5'd1 : ((snake_len > SEG_LIM) ? SEG_LIM : snake_len);
    assign last_idx = len_eff - 5'd1;

    assign seg_x  = body_x[int'(seg_idx)*COORD_W +: COORD_W];
    assign seg_y  = body_y[int'(seg_idx)*COORD_W +: COORD_W];
    assign head_x = body_x[COORD_W-1:0];
    assign head_y = body_y[COORD_W-1:0];

    assign score_new = (score == 8'hFF) ? score : score + 8'd1;
    assign acc_hit   = hit && ((score_new % 8'(ACC_EVERY)) == 8'd0);

    always_comb begin
        fsm_next   = fsm;
        load_cand  = 1'b0;
        seg_inc    = 1'b0;
        place_food = 1'b0;
        hit        = 1'b0;
        if (!in_game) begin
            fsm_next = FM_IDLE;
        end else begin
            case (fsm)
                FM_IDLE: fsm_next = FM_PLACE;
                FM_PLACE: begin
                    // Out-of-grid candidates are rejected outright; the LFSR moves on.
                    if (({1'b0, lfsr_x} < W_LIM) && ({1'b0, lfsr_y} < H_LIM)) begin
                        load_cand = 1'b1;
                        fsm_next  = FM_CHECK;
                    end
                end
                FM_CHECK: begin
                    if ((seg_x == cand_x) && (seg_y == cand_y)) begin
                        fsm_next = FM_PLACE;
                    end else if (seg_idx == last_idx) begin
                        place_food = 1'b1;
                        fsm_next   = FM_ACTIVE;
                    end else begin
                        seg_inc = 1'b1;
                    end
                end
                FM_ACTIVE: begin
                    if (step && (head_x == food_x) && (head_y == food_y)) begin
                        hit      = 1'b1;
                        fsm_next = FM_PLACE;
                    end
                end
                default: fsm_next = FM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_global_n) begin
            fsm        <= FM_IDLE;
            seg_idx    <= 5'd0;
            cand_x     <= '0;
            cand_y     <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            ate        <= 1'b0;
            accelerate <= 1'b0;
            score      <= 8'd0;
            win        <= 1'b0;
        end else begin
            fsm <= fsm_next;
            if (!in_game) begin
                food_valid <= 1'b0;
                ate        <= 1'b0;
                accelerate <= 1'b0;
                if (state == MAIN_START) begin
                    score <= 8'd0;
                    win   <= 1'b0;
                end
            end else begin
                if (load_cand) begin
                    cand_x  <= lfsr_x;
                    cand_y  <= lfsr_y;
                    seg_idx <= 5'd0;
                end
                if (seg_inc) begin
                    seg_idx <= seg_idx + 5'd1;
                end
                if (place_food) begin
                    food_x     <= cand_x;
                    food_y     <= cand_y;
                    food_valid <= 1'b1;
                end
                // Flags live exactly one step; a step outside ACTIVE never hits.
                if (step) begin
                    ate        <= hit;
                    accelerate <= acc_hit;
                end
                if (hit) begin
                    food_valid <= 1'b0;
                    score      <= score_new;
                    if (score_new >= 8'(WIN_SCORE)) begin
                        win <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
